nway_wb_cache: RTL and testbench

//  Parametrised N-way set-associative write-back/write-allocate cache between CPU load/store port and memory.

---
 rtl/nway_wb_cache_if.sv | 38 +++
 rtl/nway_wb_cache.sv | 240 ++++++++++++++++++++++++
 tb/tb_nway_wb_cache.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nway_wb_cache_if.sv
// nway_wb_cache_if: CPU load/store port and memory burst port
// of nway_wb_cache; the cache takes the slave side.
interface nway_wb_cache_if #(
  parameter int BEAT_W = 64
);
  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic [31:0]       cpu_mem_address;
  logic [3:0]        cpu_mem_byte_en;
  logic [31:0]       cpu_mem_wdata;
  logic [31:0]       cpu_mem_rdata;
  logic              cpu_mem_resp;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              error;

  modport slave (
    input  cpu_mem_read, cpu_mem_write,
    input  cpu_mem_address, cpu_mem_byte_en,
    input  cpu_mem_wdata, mem_rdata, mem_resp,
    output cpu_mem_rdata, cpu_mem_resp,
    output mem_read, mem_write, mem_address,
    output mem_wdata, error
  );

  modport master (
    output cpu_mem_read, cpu_mem_write,
    output cpu_mem_address, cpu_mem_byte_en,
    output cpu_mem_wdata, mem_rdata, mem_resp,
    input  cpu_mem_rdata, cpu_mem_resp,
    input  mem_read, mem_write, mem_address,
    input  mem_wdata, error
  );
endinterface

// File: rtl/nway_wb_cache.sv
// nway_wb_cache: N-way write-back/write-allocate cache, tree PLRU,
// burst line moves. Define CACHE_STATS_EN for hit/miss/wb counters.
module nway_wb_cache #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3,
  parameter int NUM_WAYS = 4,
  parameter int BEAT_W   = 64
) (
  input  logic           clk,
  input  logic           rst,
  nway_wb_cache_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt,
  output logic [31:0]    wb_cnt
`endif
);
  localparam int LINE_W = 8 << S_OFFSET;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int SETS   = 1 << S_INDEX;
  localparam int WORDS  = LINE_W / 32;
  localparam int TAG_W  = 32 - S_OFFSET - S_INDEX;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int BCNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int WSEL_W = S_OFFSET - 2;

  if (!(NUM_WAYS == 2 || NUM_WAYS == 4 || NUM_WAYS == 8)
      || (LINE_W % BEAT_W) != 0 || S_OFFSET < 3) begin : g_bad
    $error("nway_wb_cache: unsupported parameters");
  end

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] COMPARE   = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;
  localparam logic [1:0] REFILL    = 2'd3;

  logic [LINE_W-1:0]   data_q  [SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [SETS];
  logic [NUM_WAYS-1:0] dirty_q [SETS];
  logic [NUM_WAYS-2:0] plru_q  [SETS];

  logic [1:0]        state_q;
  logic [BCNT_W-1:0] beat_q;
  logic [WAY_W-1:0]  victim_q;
  logic              error_q;

  logic [TAG_W-1:0]   tag;
  logic [S_INDEX-1:0] idx;
  logic [WSEL_W-1:0]  wsel;
  logic               unused_ok;
  assign tag  = bus.cpu_mem_address[31 -: TAG_W];
  assign idx  = bus.cpu_mem_address[S_OFFSET +: S_INDEX];
  assign wsel = bus.cpu_mem_address[2 +: WSEL_W];
  assign unused_ok = &{1'b0, bus.cpu_mem_address[1:0]};

  logic req, both, last_beat;
  assign req  = bus.cpu_mem_read | bus.cpu_mem_write;
  assign both = bus.cpu_mem_read & bus.cpu_mem_write;
  assign last_beat = bus.mem_resp
    && beat_q == BCNT_W'(BEATS - 1);

  logic [NUM_WAYS-1:0] hit_vec;
  logic [WAY_W-1:0]    hit_way;
  logic                hit;
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w]
        && tag_q[idx][w] == tag;
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end
  assign hit = |hit_vec;

  // lowest invalid way wins; otherwise walk the PLRU tree
  logic [NUM_WAYS-2:0] plru_cur, plru_nxt;
  logic [WAY_W-1:0]    victim;
  assign plru_cur = plru_q[idx];
  always_comb begin : victim_sel
    int node, nxt;
    logic found;
    victim = '0;
    found  = 1'b0;
    node   = 0;
    for (int l = 0; l < WAY_W; l++) begin
      nxt = 2 * node + 1;
      for (int n = 0; n < NUM_WAYS - 1; n++)
        if (n == node && plru_cur[n]) nxt = 2 * node + 2;
      node = nxt;
    end
    victim = WAY_W'(node - (NUM_WAYS - 1));
    for (int w = 0; w < NUM_WAYS; w++)
      if (!found && !valid_q[idx][w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
  end

  always_comb begin : plru_upd
    int node;
    logic [WAY_W-1:0] sh;
    plru_nxt = plru_cur;
    node     = 0;
    for (int l = 0; l < WAY_W; l++) begin
      sh = hit_way >> (WAY_W - 1 - l);
      for (int n = 0; n < NUM_WAYS - 1; n++)
        if (n == node) plru_nxt[n] = ~sh[0];
      node = 2 * node + 1 + (sh[0] ? 1 : 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      victim_q <= '0;
      error_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: if (req) begin
          state_q <= COMPARE;
          if (both) error_q <= 1'b1;
        end
        COMPARE: if (hit) begin
          state_q     <= IDLE;
          plru_q[idx] <= plru_nxt;
          if (bus.cpu_mem_write)
            dirty_q[idx][hit_way] <= 1'b1;
        end else begin
          victim_q <= victim;
          state_q  <= dirty_q[idx][victim]
            ? WRITEBACK : REFILL;
        end
        WRITEBACK: if (bus.mem_resp) begin
          beat_q <= beat_q + 1'b1;
          if (last_beat) begin
            beat_q  <= '0;
            state_q <= REFILL;
          end
        end
        REFILL: if (bus.mem_resp) begin
          beat_q <= beat_q + 1'b1;
          if (last_beat) begin
            beat_q  <= '0;
            state_q <= COMPARE;
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic wr_hit;
  assign wr_hit = state_q == COMPARE && hit
    && bus.cpu_mem_write;

  always_ff @(posedge clk) begin
    if (state_q == REFILL && bus.mem_resp) begin
      for (int k = 0; k < BEATS; k++)
        if (beat_q == BCNT_W'(k))
          data_q[idx][victim_q][k*BEAT_W +: BEAT_W]
            <= bus.mem_rdata;
      if (last_beat) tag_q[idx][victim_q] <= tag;
    end
    for (int k = 0; k < WORDS; k++)
      for (int b = 0; b < 4; b++)
        if (wr_hit && wsel == WSEL_W'(k)
            && bus.cpu_mem_byte_en[b])
          data_q[idx][hit_way][k*32 + b*8 +: 8]
            <= bus.cpu_mem_wdata[b*8 +: 8];
  end

  logic [LINE_W-1:0] rd_line, wb_line;
  logic [31:0]       rd_word;
  logic [BEAT_W-1:0] wb_beat;
  assign rd_line = data_q[idx][hit_way];
  assign wb_line = data_q[idx][victim_q];
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < WORDS; k++)
      if (wsel == WSEL_W'(k)) rd_word = rd_line[k*32 +: 32];
    wb_beat = '0;
    for (int k = 0; k < BEATS; k++)
      if (beat_q == BCNT_W'(k))
        wb_beat = wb_line[k*BEAT_W +: BEAT_W];
  end

  assign bus.cpu_mem_resp  = state_q == COMPARE && hit;
  assign bus.cpu_mem_rdata = bus.cpu_mem_resp ? rd_word : '0;
  assign bus.mem_read  = state_q == REFILL;
  assign bus.mem_write = state_q == WRITEBACK;
  assign bus.mem_wdata = bus.mem_write ? wb_beat : '0;
  assign bus.error     = error_q;

  always_comb begin
    unique case (state_q)
      WRITEBACK: bus.mem_address =
        {tag_q[idx][victim_q], idx, {S_OFFSET{1'b0}}};
      REFILL: bus.mem_address =
        {tag, idx, {S_OFFSET{1'b0}}};
      default: bus.mem_address = '0;
    endcase
  end

`ifdef CACHE_STATS_EN
  // a hit right after a refill belongs to the miss already counted
  logic refilled_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refilled_q <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      wb_cnt     <= '0;
    end else begin
      if (state_q == REFILL && last_beat)
        refilled_q <= 1'b1;
      else if (state_q == IDLE)
        refilled_q <= 1'b0;
      if (state_q == COMPARE && hit && !refilled_q
          && hit_cnt != '1)
        hit_cnt <= hit_cnt + 1'b1;
      if (state_q == COMPARE && !hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + 1'b1;
      if (state_q == WRITEBACK && last_beat && wb_cnt != '1)
        wb_cnt <= wb_cnt + 1'b1;
    end
  end
`else
`endif
endmodule

// File: tb/tb_nway_wb_cache.sv
// tb_nway_wb_cache: directed vector table plus reset and burst
// sequences against a zero-wait burst memory model.
module tb_nway_wb_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nway_wb_cache_if #(.BEAT_W(64)) bus ();
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  nway_wb_cache #(
    .S_OFFSET(5), .S_INDEX(3),
    .NUM_WAYS(4), .BEAT_W(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt),
    .wb_cnt(wb_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tb_beat = 0;
  int both_hi = 0;
  logic [31:0] log_a [$];
  logic        log_w [$];
  logic [31:0] mem_m [int unsigned];

  function automatic logic [31:0] word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // zero-wait memory: one beat per cycle while a burst is requested
  initial begin
    logic [31:0] ba;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_read && bus.mem_write) both_hi++;
      if (!rst && (bus.mem_read || bus.mem_write)) begin
        if (tb_beat == 0) begin
          log_a.push_back(bus.mem_address);
          log_w.push_back(bus.mem_write);
        end
        ba = bus.mem_address + 32'(tb_beat * 8);
        if (bus.mem_write) begin
          mem_m[ba]         = bus.mem_wdata[31:0];
          mem_m[ba + 32'd4] = bus.mem_wdata[63:32];
        end
        bus.mem_rdata = {word(ba + 32'd4), word(ba)};
        bus.mem_resp  = 1'b1;
        tb_beat = (tb_beat + 1) % 4;
      end else begin
        bus.mem_resp = 1'b0;
        tb_beat = 0;
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd,
                        output logic [31:0] rdat, output int lat);
    logic got;
    @(posedge clk);
    #1;
    log_a.delete();
    log_w.delete();
    bus.cpu_mem_read    = rd;
    bus.cpu_mem_write   = wr;
    bus.cpu_mem_address = a;
    bus.cpu_mem_byte_en = be;
    bus.cpu_mem_wdata   = wd;
    got  = 1'b0;
    rdat = '0;
    lat  = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.cpu_mem_resp) begin
        rdat = bus.cpu_mem_rdata;
        lat  = c;
        got  = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cpu_mem_read  = 1'b0;
    bus.cpu_mem_write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_nb;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
    logic        exp_err;
  } vec_t;

  vec_t vt [17];

  task automatic run_vec(input string nm, input vec_t v);
    logic [31:0] rdat;
    int lat;
    do_req(v.rd, v.wr, v.addr, v.be, v.wdata, rdat, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(v.exp_lat));
    if (v.rd && !v.wr) chk({nm, "_rdata"}, rdat, v.exp_rdata);
    chk({nm, "_bursts"}, 32'(log_a.size()), 32'(v.exp_nb));
    if (v.exp_nb >= 1 && log_a.size() >= 1) begin
      chk({nm, "_addr0"}, log_a[0], v.exp_a0);
      chk({nm, "_kind0"}, 32'(log_w[0]), 32'(v.exp_nb == 2));
    end
    if (v.exp_nb == 2 && log_a.size() >= 2) begin
      chk({nm, "_addr1"}, log_a[1], v.exp_a1);
      chk({nm, "_kind1"}, 32'(log_w[1]), 32'd0);
    end
    chk({nm, "_error"}, 32'(bus.error), 32'(v.exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    vt[0]  = '{1'b1, 1'b0, 32'h040, 4'h0, 32'h0, 32'hC0DE0040, 6, 1, 32'h040, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h044, 4'h0, 32'h0, 32'hC0DE0044, 1, 0, 32'h0, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'h040, 4'hF, 32'h11223344, 32'h0, 1, 0, 32'h0, 32'h0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'h040, 4'h3, 32'hAABBCCDD, 32'h0, 1, 0, 32'h0, 32'h0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 32'h040, 4'h0, 32'h0, 32'h1122CCDD, 1, 0, 32'h0, 32'h0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 32'h05C, 4'h0, 32'h0, 32'hC0DE005C, 1, 0, 32'h0, 32'h0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 32'h140, 4'h0, 32'h0, 32'hC0DE0140, 6, 1, 32'h140, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 32'h240, 4'h0, 32'h0, 32'hC0DE0240, 6, 1, 32'h240, 32'h0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 32'h340, 4'h0, 32'h0, 32'hC0DE0340, 6, 1, 32'h340, 32'h0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 32'h440, 4'h0, 32'h0, 32'hC0DE0440, 10, 2, 32'h040, 32'h440, 1'b0};
    vt[10] = '{1'b1, 1'b0, 32'h040, 4'h0, 32'h0, 32'h1122CCDD, 6, 1, 32'h040, 32'h0, 1'b0};
    vt[11] = '{1'b1, 1'b0, 32'h244, 4'h0, 32'h0, 32'hC0DE0244, 6, 1, 32'h240, 32'h0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 32'h340, 4'h0, 32'h0, 32'hC0DE0340, 1, 0, 32'h0, 32'h0, 1'b0};
    vt[13] = '{1'b0, 1'b1, 32'h060, 4'hC, 32'h55667788, 32'h0, 6, 1, 32'h060, 32'h0, 1'b0};
    vt[14] = '{1'b1, 1'b0, 32'h060, 4'h0, 32'h0, 32'h55660060, 1, 0, 32'h0, 32'h0, 1'b0};
    vt[15] = '{1'b1, 1'b1, 32'h064, 4'hF, 32'h99990000, 32'h0, 1, 0, 32'h0, 32'h0, 1'b1};
    vt[16] = '{1'b1, 1'b0, 32'h064, 4'h0, 32'h0, 32'h99990000, 1, 0, 32'h0, 32'h0, 1'b1};

    bus.cpu_mem_read    = 1'b0;
    bus.cpu_mem_write   = 1'b0;
    bus.cpu_mem_address = '0;
    bus.cpu_mem_byte_en = '0;
    bus.cpu_mem_wdata   = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_resp", 32'(bus.cpu_mem_resp), 32'd0);
    chk("rst_rdata", bus.cpu_mem_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_address, 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 17; i++)
      run_vec($sformatf("v%0d", i), vt[i]);

`ifdef CACHE_STATS_EN
    chk("stats_hit", hit_cnt, 32'd9);
    chk("stats_miss", miss_cnt, 32'd8);
    chk("stats_wb", wb_cnt, 32'd1);
`endif

    // reset in the middle of a refill, third beat outstanding
    @(posedge clk);
    #1;
    bus.cpu_mem_read    = 1'b1;
    bus.cpu_mem_address = 32'h080;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_read && tb_beat == 2) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid_refill_reached", 32'(got), 32'd1);
    rst = 1'b1;
    bus.cpu_mem_read = 1'b0;
    #1;
    chk("mid_rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("mid_rst_resp", 32'(bus.cpu_mem_resp), 32'd0);
    chk("mid_rst_error", 32'(bus.error), 32'd0);
`ifdef CACHE_STATS_EN
    chk("mid_rst_hit_cnt", hit_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_vec("post_rst_80", '{1'b1, 1'b0, 32'h080, 4'h0, 32'h0,
            32'hC0DE0080, 6, 1, 32'h080, 32'h0, 1'b0});
    run_vec("post_rst_40", '{1'b1, 1'b0, 32'h040, 4'h0, 32'h0,
            32'h1122CCDD, 6, 1, 32'h040, 32'h0, 1'b0});
    run_vec("post_rst_84", '{1'b1, 1'b0, 32'h084, 4'h0, 32'h0,
            32'hC0DE0084, 1, 0, 32'h0, 32'h0, 1'b0});

`ifdef CACHE_STATS_EN
    chk("stats2_hit", hit_cnt, 32'd1);
    chk("stats2_miss", miss_cnt, 32'd2);
    chk("stats2_wb", wb_cnt, 32'd0);
`endif
    chk("rd_wr_exclusive", 32'(both_hi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end
endmodule
